time_base_multi: RTL and testbench

- Parametrised successor to the system time-unit generator.
- Produces the shared us_en/ms_en tick strobes from the system clock.
- Adds NUM_TIMERS independent programmable timers. Each timer counts us or ms ticks in one-shot or periodic mode and pulses on expiry.
- Consumed by the receiver controller for PGA settle delays, ADC block timing and UART report pacing.

---
 rtl/time_base_multi.sv | 143 ++++++++++++++
 tb/tb_time_base_multi.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_base_multi.sv
// System us/ms tick generator with NUM_TIMERS independent programmable
// one-shot/periodic timers counting either tick.
`timescale 1ns/1ps
module time_base_multi #(
   parameter int CLK_FREQ   = 125_000_000,
   parameter int NUM_TIMERS = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   output logic                            us_en,
   output logic                            ms_en,
   input  logic [NUM_TIMERS-1:0]           start_i,
   input  logic [NUM_TIMERS-1:0]           stop_i,
   input  logic [NUM_TIMERS*CNT_WIDTH-1:0] period_i,
   input  logic [NUM_TIMERS-1:0]           unit_ms_i,
   input  logic [NUM_TIMERS-1:0]           periodic_i,
   output logic [NUM_TIMERS-1:0]           busy_o,
   output logic [NUM_TIMERS-1:0]           expire_o
);

   localparam int US_DIV = CLK_FREQ / 1_000_000;
   localparam int UW     = (US_DIV < 2) ? 1 : $clog2(US_DIV);

   if ((CLK_FREQ % 1_000_000) != 0 || CLK_FREQ < 2_000_000 ||
       NUM_TIMERS < 1 || NUM_TIMERS > 16) begin : g_bad_param
      $error("time_base_multi: illegal CLK_FREQ or NUM_TIMERS");
   end

   typedef enum logic {IDLE, RUN} st_e;

   logic [UW-1:0] us_cnt_q, us_cnt_d;
   logic [9:0]    ms_cnt_q, ms_cnt_d;
   logic          us_en_q, us_en_d;
   logic          ms_en_q, ms_en_d;

   st_e                  st_q  [NUM_TIMERS];
   st_e                  st_d  [NUM_TIMERS];
   logic [CNT_WIDTH-1:0] per_q [NUM_TIMERS];
   logic [CNT_WIDTH-1:0] per_d [NUM_TIMERS];
   logic [CNT_WIDTH-1:0] rem_q [NUM_TIMERS];
   logic [CNT_WIDTH-1:0] rem_d [NUM_TIMERS];
   logic [NUM_TIMERS-1:0] unit_q, unit_d;
   logic [NUM_TIMERS-1:0] prd_q, prd_d;
   logic [NUM_TIMERS-1:0] exp_q, exp_d;
   logic [NUM_TIMERS-1:0] tick;

   // Prescaler: ms counter advances on the same edge that raises us_en.
   always_comb begin
      us_cnt_d = us_cnt_q + UW'(1);
      us_en_d  = 1'b0;
      ms_cnt_d = ms_cnt_q;
      ms_en_d  = 1'b0;
      if (us_cnt_q == UW'(US_DIV - 1)) begin
         us_cnt_d = '0;
         us_en_d  = 1'b1;
         if (ms_cnt_q == 10'd999) begin
            ms_cnt_d = '0;
            ms_en_d  = 1'b1;
         end else begin
            ms_cnt_d = ms_cnt_q + 10'd1;
         end
      end
   end

   assign tick = (unit_q & {NUM_TIMERS{ms_en_q}}) |
                 (~unit_q & {NUM_TIMERS{us_en_q}});

   // Channel next-state: stop beats start beats tick.
   always_comb begin
      st_d   = st_q;
      per_d  = per_q;
      rem_d  = rem_q;
      unit_d = unit_q;
      prd_d  = prd_q;
      exp_d  = '0;
      for (int k = 0; k < NUM_TIMERS; k++) begin
         if (stop_i[k]) begin
            st_d[k] = IDLE;
         end else if (start_i[k]) begin
            per_d[k]  = period_i[k*CNT_WIDTH +: CNT_WIDTH];
            rem_d[k]  = period_i[k*CNT_WIDTH +: CNT_WIDTH];
            unit_d[k] = unit_ms_i[k];
            prd_d[k]  = periodic_i[k];
            if (period_i[k*CNT_WIDTH +: CNT_WIDTH] == '0) begin
               st_d[k]  = IDLE;
               exp_d[k] = 1'b1;
            end else begin
               st_d[k] = RUN;
            end
         end else if (st_q[k] == RUN && tick[k]) begin
            if (rem_q[k] == CNT_WIDTH'(1)) begin
               exp_d[k] = 1'b1;
               if (prd_q[k]) rem_d[k] = per_q[k];
               else          st_d[k]  = IDLE;
            end else begin
               rem_d[k] = rem_q[k] - CNT_WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         us_cnt_q <= '0;
         ms_cnt_q <= '0;
         us_en_q  <= 1'b0;
         ms_en_q  <= 1'b0;
         unit_q   <= '0;
         prd_q    <= '0;
         exp_q    <= '0;
         for (int k = 0; k < NUM_TIMERS; k++) begin
            st_q[k]  <= IDLE;
            per_q[k] <= '0;
            rem_q[k] <= '0;
         end
      end else begin
         us_cnt_q <= us_cnt_d;
         ms_cnt_q <= ms_cnt_d;
         us_en_q  <= us_en_d;
         ms_en_q  <= ms_en_d;
         unit_q   <= unit_d;
         prd_q    <= prd_d;
         exp_q    <= exp_d;
         for (int k = 0; k < NUM_TIMERS; k++) begin
            st_q[k]  <= st_d[k];
            per_q[k] <= per_d[k];
            rem_q[k] <= rem_d[k];
         end
      end
   end

   always_comb begin
      us_en    = us_en_q;
      ms_en    = ms_en_q;
      expire_o = exp_q;
      busy_o   = '0;
      for (int k = 0; k < NUM_TIMERS; k++) begin
         busy_o[k] = (st_q[k] == RUN);
      end
   end

endmodule

// File: tb/tb_time_base_multi.sv
// Scoreboard bench for time_base_multi at 4 MHz with four channels.
`timescale 1ns/1ps
module tb_time_base_multi;
   localparam int NT = 4;
   localparam int CW = 16;
   localparam int US = 4;
   localparam int MS = 4000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic us_en, ms_en;
   logic [NT-1:0] start_i = '0, stop_i = '0;
   logic [NT-1:0] unit_ms_i = '0, periodic_i = '0;
   logic [NT-1:0] busy_o, expire_o;
   logic [NT*CW-1:0] period_i = '0;

   time_base_multi #(.CLK_FREQ(4_000_000), .NUM_TIMERS(NT), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .us_en(us_en), .ms_en(ms_en),
      .start_i(start_i), .stop_i(stop_i), .period_i(period_i),
      .unit_ms_i(unit_ms_i), .periodic_i(periodic_i),
      .busy_o(busy_o), .expire_o(expire_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   int rel = 0;
   bit pre_en = 1'b0;

   typedef struct {int c; logic [NT-1:0] m;} exp_t;
   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc - rel, act, exp);
      end
   endtask

   // Nth tick strictly after the cycle in which start was driven.
   function automatic int nth(input int s, input int n, input bit ms);
      int per;
      int base;
      per  = ms ? MS : US;
      base = (s < rel) ? rel : s;
      return rel + ((base - rel) / per + 1) * per + (n - 1) * per;
   endfunction

   function automatic logic [NT-1:0] pop_due(input int c);
      logic [NT-1:0] m;
      m = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].c == c) begin
            m |= sb[i].m;
            sb.delete(i);
         end
      end
      return m;
   endfunction

   function automatic logic [1:0] pre_exp(input int c);
      int d;
      d = c - rel;
      return {d > 0 && d % US == 0, d > 0 && d % MS == 0};
   endfunction

   task automatic mon_cycle();
      logic [NT-1:0] m;
      m = pop_due(cyc);
      if (m != '0 || expire_o != '0) chk("expire", expire_o, m);
      if (pre_en) chk("prescale", {us_en, ms_en}, pre_exp(cyc));
   endtask

   always @(negedge clk) mon_cycle();

   task automatic step();
      @(negedge clk);
      start_i = '0;
      stop_i  = '0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   task automatic start_ch(input int ch, input int per, input bit ms, input bit pd);
      start_i[ch]            = 1'b1;
      period_i[ch*CW +: CW]  = CW'(per);
      unit_ms_i[ch]          = ms;
      periodic_i[ch]         = pd;
   endtask

   task automatic push(input int c, input logic [NT-1:0] m);
      exp_t e;
      e.c = c;
      e.m = m;
      sb.push_back(e);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s, e, t, r0;
      repeat (3) @(negedge clk);
      chk("reset_out", {us_en, ms_en, busy_o, expire_o}, 0);
      rst    = 1'b0;
      rel    = cyc;
      pre_en = 1'b1;
      r0     = rel;

      wait_until(r0 + 2);
      s = cyc;
      start_ch(1, 3, 1'b1, 1'b1);
      push(nth(s, 3, 1'b1) + 1, 4'b0010);
      push(nth(s, 6, 1'b1) + 1, 4'b0010);
      step();
      chk("busy1_start", busy_o[1], 1);

      wait_until(r0 + 10 + int'($urandom_range(0, 3)));
      s = cyc;
      start_ch(0, 5, 1'b0, 1'b0);
      e = nth(s, 5, 1'b0) + 1;
      push(e, 4'b0001);
      step();
      chk("busy0_start", busy_o[0], 1);
      wait_until(e - 1);
      chk("busy0_hold", busy_o[0], 1);
      step();
      chk("busy0_fall", busy_o[0], 0);

      s = cyc;
      start_ch(2, 0, 1'b0, 1'b0);
      push(s + 1, 4'b0100);
      step();
      chk("zero_busy", busy_o[2], 0);
      step();
      chk("zero_busy2", busy_o[2], 0);
      s = cyc;
      start_ch(2, 0, 1'b0, 1'b1);
      push(s + 1, 4'b0100);
      step();
      chk("zero_prd_busy", busy_o[2], 0);

      s = cyc;
      start_ch(3, 20, 1'b0, 1'b0);
      step();
      wait_until(s + 22);
      s = cyc;
      start_ch(3, 10, 1'b0, 1'b0);
      e = nth(s, 10, 1'b0) + 1;
      push(e, 4'b1000);
      step();
      chk("restart_busy", busy_o[3], 1);
      wait_until(e);
      chk("restart_fall", busy_o[3], 0);
      wait_until(e + 40);

      s = cyc;
      start_ch(0, 5, 1'b0, 1'b0);
      step();
      wait_until(s + 6);
      start_ch(0, 5, 1'b0, 1'b0);
      stop_i[0] = 1'b1;
      step();
      chk("stopstart_busy", busy_o[0], 0);
      wait_until(s + 60);

      s = cyc;
      start_ch(2, 2, 1'b0, 1'b0);
      t = nth(s, 2, 1'b0);
      step();
      wait_until(t);
      stop_i[2] = 1'b1;
      step();
      chk("stopterm_busy", busy_o[2], 0);
      wait_until(t + 20);

      wait_until(r0 + 24005);
      chk("busy1_run", busy_o[1], 1);
      wait_until(r0 + 24010);
      stop_i[1] = 1'b1;
      step();
      chk("stop1_busy", busy_o[1], 0);

      s = cyc;
      for (int ch = 0; ch < NT; ch++) start_ch(ch, 3, 1'b0, 1'b0);
      e = nth(s, 3, 1'b0) + 1;
      push(e, 4'b1111);
      step();
      wait_until(e);
      chk("all4", expire_o, 4'b1111);
      step();
      chk("all4_once", expire_o, 0);

      s = cyc;
      for (int ch = 0; ch < NT; ch++) start_ch(ch, 4, 1'b0, 1'b0);
      step();
      wait_until(nth(s, 2, 1'b0) + 1);
      rst    = 1'b1;
      pre_en = 1'b0;
      step();
      chk("rst_mid_out", {us_en, ms_en, busy_o, expire_o}, 0);
      step();
      step();
      rst    = 1'b0;
      rel    = cyc;
      pre_en = 1'b1;
      wait_until(cyc + 60);

      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
